// File: rtl/key_bcd_counter_pkg.sv
// rtl/key_bcd_counter_pkg.sv - shared constants, FSM state type and BCD/segment helpers
// Contents:
//   SEG_0..SEG_9, SEG_BLANK : seven-segment codes {g,f,e,d,c,b,a}, active-high
//   rpt_state_e             : per-key auto-repeat FSM states
//   seg7()                  : BCD digit to segment code, blank for non-digits
//   bcd_inc() / bcd_dec()   : add/subtract one across up to 8 BCD digits
package key_bcd_counter_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    RPT_IDLE       = 2'd0,
    RPT_PRESS_WAIT = 2'd1,
    RPT_REPEAT     = 2'd2
  } rpt_state_e;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Callers never pass the all-nines value, so the carry always stops inside
  // the populated digits and the unused upper digits stay zero.
  function automatic logic [31:0] bcd_inc(input logic [31:0] v);
    logic [31:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Callers never pass zero, so the borrow always stops inside the populated digits.
  function automatic logic [31:0] bcd_dec(input logic [31:0] v);
    logic [31:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/key_bcd_counter_if.sv
// rtl/key_bcd_counter_if.sv - key inputs and display/value outputs of the counter
// Signals:
//   I_key_up/I_key_down/I_key_clr : raw keys, high = pressed, asynchronous
//   O_led   : segments {g,f,e,d,c,b,a}, active-high
//   O_dx    : one-hot digit select, bit 0 = least significant digit
//   O_value : BCD count, nibble 0 = least significant digit
//   O_wrap  : one-cycle pulse when a step wraps
// Modports: master = board/bench side, slave = counter side.
interface key_bcd_counter_if #(
  parameter int DIGITS = 2
);
  logic                  I_key_up;
  logic                  I_key_down;
  logic                  I_key_clr;
  logic [6:0]            O_led;
  logic [DIGITS-1:0]     O_dx;
  logic [4*DIGITS-1:0]   O_value;
  logic                  O_wrap;

  modport master (
    output I_key_up, I_key_down, I_key_clr,
    input  O_led, O_dx, O_value, O_wrap
  );

  modport slave (
    input  I_key_up, I_key_down, I_key_clr,
    output O_led, O_dx, O_value, O_wrap
  );
endinterface

// File: rtl/key_bcd_counter_key_debounce_repeat.sv
// rtl/key_bcd_counter_key_debounce_repeat.sv - key synchronizer, debouncer and auto-repeat step generator
// Ports:
//   I_clk, I_rst_n : clock, asynchronous active-low reset
//   I_key          : raw key, high = pressed, asynchronous to I_clk
//   O_step         : registered one-cycle step pulse (press, then auto-repeat)
module key_debounce_repeat
  import key_bcd_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter bit EN_REPEAT    = 1'b1
) (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_key,
  output logic O_step
);

  localparam int DW   = $clog2(DEBOUNCE_CYC + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYC - 1);
  localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          step_q, step_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  rpt_state_e    state_q, state_d;

  // db_cnt counts consecutive samples that disagree with the debounced level;
  // any agreeing sample restarts it, so only a clean run flips the level.
  always_comb begin
    sync1_d  = I_key;
    sync2_d  = sync1_q;
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end
  end

  // Decisions use level_d so the press step leaves in the same edge as the
  // level flip, and a release cancels a repeat due in that very edge.
  // IDLE with level_d high can only mean a fresh rising edge.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    step_d  = 1'b0;
    if (!level_d) begin
      state_d = RPT_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        RPT_IDLE: begin
          state_d = RPT_PRESS_WAIT;
          timer_d = '0;
          step_d  = 1'b1;
        end
        RPT_PRESS_WAIT: begin
          if (EN_REPEAT) begin
            if (timer_q == DELAY_LAST) begin
              state_d = RPT_REPEAT;
              timer_d = '0;
              step_d  = 1'b1;
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
        end
        RPT_REPEAT: begin
          if (timer_q == RATE_LAST) begin
            timer_d = '0;
            step_d  = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = RPT_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
      timer_q  <= '0;
      state_q  <= RPT_IDLE;
      step_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      timer_q  <= timer_d;
      state_q  <= state_d;
      step_q   <= step_d;
    end
  end

  assign O_step = step_q;

endmodule

// File: rtl/key_bcd_counter.sv
// rtl/key_bcd_counter.sv - three-key BCD up/down/clear counter with multiplexed seven-segment display
// Ports:
//   I_clk, I_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : raw keys in; O_led, O_dx, O_value, O_wrap out (all registered)
module key_bcd_counter
  import key_bcd_counter_pkg::*;
#(
  parameter int DIGITS       = 2,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int SCAN_CYC     = 50000,
  parameter int WRAP         = 1
) (
  input  logic           I_clk,
  input  logic           I_rst_n,
  key_bcd_counter_if.slave bus
);

  localparam int VW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW = $clog2(SCAN_CYC + 1);

  localparam logic [VW-1:0] MAX_VAL   = {DIGITS{4'h9}};
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic step_up, step_down, step_clr;

  logic [VW-1:0]     value_q, value_d;
  logic              wrap_q, wrap_d;
  logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]     scan_idx_q, scan_idx_d;
  logic [DIGITS-1:0] dx_q, dx_d;
  logic [6:0]        led_q, led_d;
  logic [3:0]        nibble;

  key_debounce_repeat #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .EN_REPEAT   (1'b1)
  ) u_key_up (
    .I_clk  (I_clk),
    .I_rst_n(I_rst_n),
    .I_key  (bus.I_key_up),
    .O_step (step_up)
  );

  key_debounce_repeat #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .EN_REPEAT   (1'b1)
  ) u_key_down (
    .I_clk  (I_clk),
    .I_rst_n(I_rst_n),
    .I_key  (bus.I_key_down),
    .O_step (step_down)
  );

  key_debounce_repeat #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .EN_REPEAT   (1'b0)
  ) u_key_clr (
    .I_clk  (I_clk),
    .I_rst_n(I_rst_n),
    .I_key  (bus.I_key_clr),
    .O_step (step_clr)
  );

  // Clear beats everything; simultaneous up and down cancel out.
  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    if (step_clr) begin
      value_d = '0;
    end else if (step_up && !step_down) begin
      if (value_q == MAX_VAL) begin
        if (WRAP != 0) begin
          value_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        value_d = VW'(bcd_inc(32'(value_q)));
      end
    end else if (step_down && !step_up) begin
      if (value_q == '0) begin
        if (WRAP != 0) begin
          value_d = MAX_VAL;
          wrap_d  = 1'b1;
        end
      end else begin
        value_d = VW'(bcd_dec(32'(value_q)));
      end
    end
  end

  // Digit scan; the select and segments are registered from the current
  // index and value, so any change shows on the pins one cycle later.
  always_comb begin
    scan_cnt_d = scan_cnt_q + SW'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IW'(1);
    end

    dx_d   = '0;
    nibble = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx_q == IW'(i)) begin
        dx_d[i] = 1'b1;
        nibble  = value_q[4*i +: 4];
      end
    end
    led_d = seg7(nibble);
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      value_q    <= '0;
      wrap_q     <= 1'b0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      dx_q       <= '0;
      led_q      <= SEG_BLANK;
    end else begin
      value_q    <= value_d;
      wrap_q     <= wrap_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      dx_q       <= dx_d;
      led_q      <= led_d;
    end
  end

  assign bus.O_value = value_q;
  assign bus.O_wrap  = wrap_q;
  assign bus.O_dx    = dx_q;
  assign bus.O_led   = led_q;

endmodule

// File: tb/tb_key_bcd_counter.sv
// tb/tb_key_bcd_counter.sv - scoreboard bench for key_bcd_counter (wrap and saturate instances)
module tb_key_bcd_counter;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam int SC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_up = 1'b0;
  logic key_down = 1'b0;
  logic key_clr = 1'b0;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_bcd_counter_if #(.DIGITS(2)) bus_a ();
  key_bcd_counter_if #(.DIGITS(2)) bus_b ();

  assign bus_a.I_key_up   = key_up;
  assign bus_a.I_key_down = key_down;
  assign bus_a.I_key_clr  = key_clr;
  assign bus_b.I_key_up   = key_up;
  assign bus_b.I_key_down = key_down;
  assign bus_b.I_key_clr  = key_clr;

  key_bcd_counter #(
    .DIGITS(2), .DEBOUNCE_CYC(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
    .SCAN_CYC(SC), .WRAP(1)
  ) u_dut_wrap (
    .I_clk  (clk),
    .I_rst_n(rst_n),
    .bus    (bus_a)
  );

  key_bcd_counter #(
    .DIGITS(2), .DEBOUNCE_CYC(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
    .SCAN_CYC(SC), .WRAP(0)
  ) u_dut_sat (
    .I_clk  (clk),
    .I_rst_n(rst_n),
    .bus    (bus_b)
  );

  typedef struct {
    logic [7:0] val;
    int         cyc;
    logic       wrap;
  } exp_t;

  exp_t       qa[$];
  exp_t       qb[$];
  int         va = 0;
  int         vb = 0;
  logic [7:0] prev_a = 8'h00;
  logic [7:0] prev_b = 8'h00;
  bit         mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic void next_val(input bit wrap_en, input bit up, input bit dn, input bit clr,
                                   input int v, output int nv, output bit w);
    nv = v;
    w  = 1'b0;
    if (clr) begin
      nv = 0;
    end else if (up && !dn) begin
      if (v == 99) begin
        if (wrap_en) begin nv = 0; w = 1'b1; end
      end else begin
        nv = v + 1;
      end
    end else if (dn && !up) begin
      if (v == 0) begin
        if (wrap_en) begin nv = 99; w = 1'b1; end
      end else begin
        nv = v - 1;
      end
    end
  endfunction

  // Edge on which the k-th step of a hold leaves the key block (press at n0).
  function automatic int step_at(input int n0, input int k);
    if (k == 1) return n0 + DB + 2;
    return n0 + DB + 2 + RD + RR * (k - 2);
  endfunction

  // Queue the value change a step causes; `at` is the cycle the new value shows.
  task automatic apply_step(input bit up, input bit dn, input bit clr, input int at);
    int   nv;
    bit   w;
    exp_t e;
    next_val(1'b1, up, dn, clr, va, nv, w);
    if (nv != va) begin
      e.val = to_bcd(nv); e.cyc = at; e.wrap = w;
      qa.push_back(e);
      va = nv;
    end
    next_val(1'b0, up, dn, clr, vb, nv, w);
    if (nv != vb) begin
      e.val = to_bcd(nv); e.cyc = at; e.wrap = w;
      qb.push_back(e);
      vb = nv;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  // Press the given keys cleanly and hold them long enough for exactly
  // `steps` step events, releasing 3 cycles before the last step so the
  // debounced release lands between that step and the next.
  task automatic press(input bit up, input bit dn, input bit clr, input int steps);
    int n0;
    int rel;
    @(posedge clk); #1;
    key_up = up; key_down = dn; key_clr = clr;
    n0 = cyc;
    for (int k = 1; k <= steps; k++) begin
      apply_step(up, dn, (k == 1) ? clr : 1'b0, step_at(n0, k) + 1);
    end
    rel = (steps == 1) ? n0 + 10 : step_at(n0, steps) - 3;
    wait_until(rel);
    key_up = 1'b0; key_down = 1'b0; key_clr = 1'b0;
    repeat (DB + 10) @(posedge clk);
    #1;
    check("a_pending", qa.size(), 0);
    check("b_pending", qb.size(), 0);
  endtask

  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus_a.O_value !== prev_a) begin
          if (qa.size() == 0) begin
            check("a_unexpected_change", 32'(bus_a.O_value), 32'(prev_a));
          end else begin
            e = qa.pop_front();
            check("a_value", 32'(bus_a.O_value), 32'(e.val));
            check("a_time", cyc, e.cyc);
            check("a_wrap", 32'(bus_a.O_wrap), 32'(e.wrap));
          end
        end else if (bus_a.O_wrap !== 1'b0) begin
          check("a_wrap_idle", 32'(bus_a.O_wrap), 0);
        end
        prev_a = bus_a.O_value;
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus_b.O_value !== prev_b) begin
          if (qb.size() == 0) begin
            check("b_unexpected_change", 32'(bus_b.O_value), 32'(prev_b));
          end else begin
            e = qb.pop_front();
            check("b_value", 32'(bus_b.O_value), 32'(e.val));
            check("b_time", cyc, e.cyc);
            check("b_wrap", 32'(bus_b.O_wrap), 32'(e.wrap));
          end
        end else if (bus_b.O_wrap !== 1'b0) begin
          check("b_wrap_idle", 32'(bus_b.O_wrap), 0);
        end
        prev_b = bus_b.O_value;
      end
    end
  end

  initial begin : stim
    logic [1:0] pdx;
    logic [6:0] exp_led;
    int         last_chg;
    int         n0;
    int         n1;

    // Reset state and first display cycle after release.
    #12;
    check("rst_value", 32'(bus_a.O_value), 0);
    check("rst_wrap", 32'(bus_a.O_wrap), 0);
    check("rst_dx", 32'(bus_a.O_dx), 0);
    check("rst_led", 32'(bus_a.O_led), 0);
    check("rst_value_sat", 32'(bus_b.O_value), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_dx", 32'(bus_a.O_dx), 32'h1);
    check("first_led", 32'(bus_a.O_led), 32'h3F);
    mon_en = 1'b1;

    // 1: a 3-cycle glitch gives no step, a clean press steps 7 cycles after the edge.
    @(posedge clk); #1;
    key_up = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    key_up = 1'b0;
    repeat (4) @(posedge clk);
    press(1'b1, 1'b0, 1'b0, 1);
    check("t1_value", 32'(bus_a.O_value), 32'h01);

    // 2: hold with auto-repeat to 05.
    press(1'b0, 1'b0, 1'b1, 1);
    press(1'b1, 1'b0, 1'b0, 5);
    check("t2_value", 32'(bus_a.O_value), 32'h05);

    // 3: wrap versus saturate at both limits.
    press(1'b0, 1'b0, 1'b1, 1);
    press(1'b0, 1'b1, 1'b0, 1);
    check("t3_wrap_down", 32'(bus_a.O_value), 32'h99);
    check("t3_sat_floor", 32'(bus_b.O_value), 32'h00);
    press(1'b1, 1'b0, 1'b0, 1);
    press(1'b0, 1'b0, 1'b1, 1);
    press(1'b1, 1'b0, 1'b0, 100);
    check("t3_wrap_up", 32'(bus_a.O_value), 32'h00);
    check("t3_sat_ceiling", 32'(bus_b.O_value), 32'h99);
    press(1'b1, 1'b0, 1'b0, 1);
    check("t3_after_wrap", 32'(bus_a.O_value), 32'h01);
    check("t3_sat_hold", 32'(bus_b.O_value), 32'h99);

    // 4: up+down cancel, clear beats up.
    press(1'b0, 1'b0, 1'b1, 1);
    press(1'b1, 1'b0, 1'b0, 1);
    press(1'b1, 1'b1, 1'b0, 1);
    check("t4_up_down", 32'(bus_a.O_value), 32'h01);
    press(1'b1, 1'b0, 1'b1, 1);
    check("t4_clr_up", 32'(bus_a.O_value), 32'h00);

    // 5: display scan of 47.
    press(1'b1, 1'b0, 1'b0, 47);
    check("t5_value", 32'(bus_a.O_value), 32'h47);
    last_chg = -1;
    @(negedge clk);
    pdx = bus_a.O_dx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("t5_onehot", $countones(bus_a.O_dx), 1);
      exp_led = (bus_a.O_dx == 2'b01) ? 7'h07 : 7'h66;
      check("t5_led", 32'(bus_a.O_led), 32'(exp_led));
      if (bus_a.O_dx != pdx) begin
        if (last_chg >= 0) check("t5_period", cyc - last_chg, SC);
        last_chg = cyc;
      end
      pdx = bus_a.O_dx;
    end

    // 6: reset during a repeat hold at 12, key still held afterwards.
    press(1'b0, 1'b0, 1'b1, 1);
    @(posedge clk); #1;
    key_up = 1'b1;
    n0 = cyc;
    for (int k = 1; k <= 12; k++) apply_step(1'b1, 1'b0, 1'b0, step_at(n0, k) + 1);
    wait_until(step_at(n0, 12) + 2);
    check("t6_pre_reset", 32'(bus_a.O_value), 32'h12);
    check("t6_queue", qa.size(), 0);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_rst_value", 32'(bus_a.O_value), 0);
    check("t6_rst_wrap", 32'(bus_a.O_wrap), 0);
    check("t6_rst_dx", 32'(bus_a.O_dx), 0);
    check("t6_rst_led", 32'(bus_a.O_led), 0);
    check("t6_rst_value_sat", 32'(bus_b.O_value), 0);
    va = 0; vb = 0; prev_a = 8'h00; prev_b = 8'h00;
    @(posedge clk); #2;
    rst_n = 1'b1;
    n1 = cyc;
    apply_step(1'b1, 1'b0, 1'b0, n1 + DB + 3);
    mon_en = 1'b1;
    wait_until(n1 + 10);
    key_up = 1'b0;
    repeat (DB + 10) @(posedge clk);
    #1;
    check("t6_pending", qa.size(), 0);
    check("t6_value", 32'(bus_a.O_value), 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
